// File: rtl/pdp_exec_mem_responder.sv
// Memory responder for the EXEC unit: one access per cycle to a single-ported word array,
// shared by EXEC read/write, instruction fetch and a sequential program loader.
module pdp_exec_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  protocol_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;
    localparam logic [ADDR_WIDTH:0] LOAD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  ifu_pend;
    logic [ADDR_WIDTH-1:0] ifu_pend_addr;
    logic                  exec_busy;
    logic                  ifu_serve_pend;
    logic                  ifu_serve_new;
    logic                  load_xfer;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH:0]   load_count_next;

    assign exec_busy      = exec_wr_req | exec_rd_req;
    assign ifu_serve_pend = !exec_busy && ifu_pend;
    assign ifu_serve_new  = !exec_busy && !ifu_pend && ifu_rd_req;

    // Loader handshake: a word moves on a cycle where load_valid && load_ready. load_ready is
    // only offered when no EXEC/IFU access claims the array and no restart is in progress.
    assign load_ready = (state == LOAD) && !exec_busy && !ifu_pend && !ifu_rd_req && !load_start;
    assign load_xfer  = load_ready && load_valid;
    assign load_count_next = load_count + 1'b1;

    always_comb begin
        mem_we    = exec_wr_req | load_xfer;
        mem_waddr = exec_wr_req ? exec_wr_addr : load_addr;
        mem_wdata = exec_wr_req ? exec_wr_data : load_data;
    end

    // Array contents survive reset, so the storage has no reset term.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_rd_data  <= '0;
            ifu_rd_data   <= '0;
            ifu_rd_valid  <= 1'b0;
            ifu_pend      <= 1'b0;
            ifu_pend_addr <= '0;
            protocol_err  <= 1'b0;
        end else begin
            ifu_rd_valid <= 1'b0;
            if ((exec_wr_req && exec_rd_req) || (ifu_rd_req && ifu_pend)) protocol_err <= 1'b1;
            if (exec_rd_req && !exec_wr_req) exec_rd_data <= mem[exec_rd_addr];
            if (ifu_serve_pend) begin
                ifu_rd_data  <= mem[ifu_pend_addr];
                ifu_rd_valid <= 1'b1;
                ifu_pend     <= 1'b0;
            end else if (ifu_serve_new) begin
                ifu_rd_data  <= mem[ifu_rd_addr];
                ifu_rd_valid <= 1'b1;
            end else if (exec_busy && ifu_rd_req && !ifu_pend) begin
                ifu_pend      <= 1'b1;
                ifu_pend_addr <= ifu_rd_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            load_addr  <= '0;
            load_count <= '0;
        end else if (load_start) begin
            state      <= LOAD;
            load_addr  <= load_base;
            load_count <= '0;
        end else if (load_xfer) begin
            load_addr  <= load_addr + 1'b1;
            load_count <= load_count_next;
            if (load_count_next == LOAD_MAX) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_pdp_exec_mem_responder.sv
// Directed bench for pdp_exec_mem_responder: read results go through expected queues that a
// negedge monitor drains, while state flags are compared inline by the stimulus thread.
module tb_pdp_exec_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exec_rd_req = 1'b0;
    logic [11:0] exec_rd_addr = '0;
    logic [11:0] exec_rd_data;
    logic        exec_wr_req = 1'b0;
    logic [11:0] exec_wr_addr = '0;
    logic [11:0] exec_wr_data = '0;
    logic        ifu_rd_req = 1'b0;
    logic [11:0] ifu_rd_addr = '0;
    logic [11:0] ifu_rd_data;
    logic        ifu_rd_valid;
    logic        load_start = 1'b0;
    logic [11:0] load_base = '0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = '0;
    logic        load_ready;
    logic [12:0] load_count;
    logic        protocol_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic exec_fire_d;

    logic [11:0] exec_q[$];
    logic [11:0] ifu_q[$];
    int          ifu_cyc_q[$];

    pdp_exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
        .ifu_rd_valid(ifu_rd_valid),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .load_count(load_count),
        .protocol_err(protocol_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge reset)
        if (reset) exec_fire_d <= 1'b0;
        else       exec_fire_d <= exec_rd_req && !exec_wr_req;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (exec_fire_d) begin
                if (exec_q.size() == 0) check("exec_unexpected", 32'd1, 32'd0);
                else check("exec_rd_data", {20'd0, exec_rd_data}, {20'd0, exec_q.pop_front()});
            end
            if (ifu_rd_valid) begin
                if (ifu_q.size() == 0) check("ifu_unexpected_valid", 32'd1, 32'd0);
                else begin
                    check("ifu_rd_data", {20'd0, ifu_rd_data}, {20'd0, ifu_q.pop_front()});
                    check("ifu_latency_cycle", cyc, ifu_cyc_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exec_write(input logic [11:0] a, input logic [11:0] d);
        exec_wr_req = 1'b1; exec_wr_addr = a; exec_wr_data = d;
        step();
        exec_wr_req = 1'b0;
    endtask

    task automatic exec_read(input logic [11:0] a, input logic [11:0] e);
        exec_rd_req = 1'b1; exec_rd_addr = a; exec_q.push_back(e);
        step();
        exec_rd_req = 1'b0;
    endtask

    task automatic ifu_read(input logic [11:0] a, input logic [11:0] e);
        ifu_rd_req = 1'b1; ifu_rd_addr = a;
        ifu_q.push_back(e); ifu_cyc_q.push_back(cyc + 1);
        step();
        ifu_rd_req = 1'b0;
    endtask

    task automatic start_load(input logic [11:0] base);
        load_start = 1'b1; load_base = base;
        step();
        load_start = 1'b0;
    endtask

    task automatic load_word(input logic [11:0] d);
        load_valid = 1'b1; load_data = d;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (load_ready) begin
                step();
                load_valid = 1'b0;
                return;
            end
            step();
        end
        load_valid = 1'b0;
        check("load_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // reset values
        #3;
        check("rst_exec_rd_data", {20'd0, exec_rd_data}, 32'd0);
        check("rst_ifu_rd_valid", {31'd0, ifu_rd_valid}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_load_count", {19'd0, load_count}, 32'd0);
        check("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // idle loader ignores load_valid
        load_valid = 1'b1; load_data = 12'h777;
        #1;
        check("idle_load_ready", {31'd0, load_ready}, 32'd0);
        step();
        load_valid = 1'b0;
        check("idle_load_count", {19'd0, load_count}, 32'd0);

        // 1: load burst then exec read
        start_load(12'h200);
        load_word(12'h200);
        load_word(12'h234);
        load_word(12'hFFF);
        check("load_count_3", {19'd0, load_count}, 32'd3);
        exec_read(12'h201, 12'h234);
        exec_read(12'h200, 12'h200);
        exec_read(12'h202, 12'hFFF);
        idle(1);

        // 2: write then read-after-write
        exec_write(12'h050, 12'hABC);
        exec_read(12'h050, 12'hABC);
        idle(1);
        check("t2_protocol_err", {31'd0, protocol_err}, 32'd0);

        // 3: IFU collides with exec read -> deferred by one cycle
        exec_write(12'h010, 12'h111);
        exec_write(12'h020, 12'h222);
        exec_rd_req = 1'b1; exec_rd_addr = 12'h020; exec_q.push_back(12'h222);
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'h010;
        ifu_q.push_back(12'h111); ifu_cyc_q.push_back(cyc + 2);
        step();
        exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
        idle(3);
        ifu_read(12'h050, 12'hABC);
        idle(2);
        check("t3_protocol_err", {31'd0, protocol_err}, 32'd0);

        // 4: wrapping load, stalled by a 2-cycle exec read
        start_load(12'hFFE);
        load_word(12'd1);
        load_word(12'd2);
        load_valid = 1'b1; load_data = 12'd3;
        exec_rd_req = 1'b1; exec_rd_addr = 12'h201; exec_q.push_back(12'h234);
        #1;
        check("t4_ready_low_1", {31'd0, load_ready}, 32'd0);
        step();
        exec_q.push_back(12'h234);
        #1;
        check("t4_ready_low_2", {31'd0, load_ready}, 32'd0);
        step();
        exec_rd_req = 1'b0;
        #1;
        check("t4_ready_back", {31'd0, load_ready}, 32'd1);
        step();
        load_data = 12'd4;
        #1;
        check("t4_ready_w4", {31'd0, load_ready}, 32'd1);
        step();
        load_valid = 1'b0;
        check("t4_load_count", {19'd0, load_count}, 32'd4);
        exec_read(12'hFFE, 12'd1);
        exec_read(12'hFFF, 12'd2);
        exec_read(12'h000, 12'd3);
        exec_read(12'h001, 12'd4);
        idle(1);

        // 5: simultaneous read and write
        exec_rd_req = 1'b1; exec_rd_addr = 12'h030;
        exec_wr_req = 1'b1; exec_wr_addr = 12'h030; exec_wr_data = 12'h555;
        step();
        exec_rd_req = 1'b0; exec_wr_req = 1'b0;
        check("t5_rd_data_held", {20'd0, exec_rd_data}, 32'h004);
        check("t5_protocol_err", {31'd0, protocol_err}, 32'd1);
        exec_read(12'h030, 12'h555);
        idle(2);
        check("t5_err_sticky", {31'd0, protocol_err}, 32'd1);

        // 6: reset while an IFU fetch is pending
        exec_wr_req = 1'b1; exec_wr_addr = 12'h060; exec_wr_data = 12'h333;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'h010;
        step();
        exec_wr_req = 1'b0; ifu_rd_req = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_exec_rd_data", {20'd0, exec_rd_data}, 32'd0);
        check("t6_ifu_rd_data", {20'd0, ifu_rd_data}, 32'd0);
        check("t6_ifu_rd_valid", {31'd0, ifu_rd_valid}, 32'd0);
        check("t6_load_count", {19'd0, load_count}, 32'd0);
        check("t6_protocol_err", {31'd0, protocol_err}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(5);
        exec_read(12'h060, 12'h333);
        exec_read(12'h050, 12'hABC);
        ifu_read(12'h010, 12'h111);
        idle(4);

        check("exec_q_drained", exec_q.size(), 32'd0);
        check("ifu_q_drained", ifu_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
